reg_file_gen: RTL and testbench

//  Parametrised CPU register file: 2^ADDR_W x DATA_W, two registered read ports, one write port.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_clr_seq.sv | 79 +++++++
 rtl/reg_file_gen.sv | 120 ++++++++++++
 tb/tb_reg_file_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the CPU register file and its clear sequencer.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32'd16;
  localparam int DEF_ADDR_W = 32'd4;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

  // Register 0 is hardwired to zero, so the sweep and the write port never target it.
  function automatic logic is_zero_addr(input logic [DEF_ADDR_W-1:0] addr_a);
    return (addr_a == {DEF_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: on a clear request, walks addresses 1..DEPTH-1 issuing one zero-write per enabled cycle.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic              i_clr,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              clr_we_s;

  // Sequencer state, counter and busy flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= {ADDR_W{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; a request while already sweeping is ignored.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    clr_we_s = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (i_ce && i_clr) begin
          state_d = CLR_SWEEP;
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
        end else begin
          state_d = CLR_IDLE;
        end
      end
      CLR_SWEEP: begin
        if (i_ce) begin
          clr_we_s = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = CLR_IDLE;
            cnt_d   = {ADDR_W{1'b0}};
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = CLR_SWEEP;
        end
      end
      default: begin
        state_d = CLR_IDLE;
        cnt_d   = {ADDR_W{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_clr_we   = clr_we_s;
  assign o_clr_addr = cnt_q;
  assign o_busy     = busy_q;

endmodule

// File: rtl/reg_file_gen.sv
// CPU register file: 2^ADDR_W x DATA_W, two registered read ports, one write port, segment mirrors
// and a hardware clear sweep. Define REGFILE_BYPASS_EN to forward same-cycle accepted writes to reads.
module reg_file_gen
  import reg_file_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SEG_C_ADDR = 32'd14,
  parameter int SEG_D_ADDR = 32'd15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_w_addr,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic [ADDR_W-1:0] i_r1_addr,
  input  logic [ADDR_W-1:0] i_r2_addr,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_r1_data,
  output logic [DATA_W-1:0] o_r2_data,
  output logic [DATA_W-1:0] o_seg_c,
  output logic [DATA_W-1:0] o_seg_d,
  output logic              o_busy
);

  localparam int                DEPTH   = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A  = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_D  = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] SEG_C_A = ADDR_W'(SEG_C_ADDR);
  localparam logic [ADDR_W-1:0] SEG_D_A = ADDR_W'(SEG_D_ADDR);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d, seg_c_q, seg_c_d, seg_d_q, seg_d_d;

  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              busy_s;
  logic              wr_acc_s;
  logic              arr_we_s;
  logic [ADDR_W-1:0] arr_addr_s;
  logic [DATA_W-1:0] arr_data_s;

  reg_file_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ce       (i_ce),
    .i_clr      (i_clr),
    .o_clr_we   (clr_we_s),
    .o_clr_addr (clr_addr_s),
    .o_busy     (busy_s)
  );

  // A user write is dropped while sweeping or when a clear is requested in the same cycle.
  assign wr_acc_s = i_ce & i_we & (i_w_addr != ZERO_A) & ~busy_s & ~i_clr;

  // Array port arbitration: the sweep owns the port whenever it is active.
  always_comb begin
    arr_we_s   = 1'b0;
    arr_addr_s = i_w_addr;
    arr_data_s = i_w_data;
    if (clr_we_s) begin
      arr_we_s   = 1'b1;
      arr_addr_s = clr_addr_s;
      arr_data_s = ZERO_D;
    end else begin
      arr_we_s   = wr_acc_s;
    end
  end

  // Register array storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ZERO_D;
      end
    end else if (arr_we_s) begin
      mem_q[arr_addr_s] <= arr_data_s;
    end
  end

  // Read and segment next values: old array contents, address 0 forced to zero.
  always_comb begin
    r1_d    = (i_r1_addr == ZERO_A) ? ZERO_D : mem_q[i_r1_addr];
    r2_d    = (i_r2_addr == ZERO_A) ? ZERO_D : mem_q[i_r2_addr];
    seg_c_d = (SEG_C_A == ZERO_A)   ? ZERO_D : mem_q[SEG_C_A];
    seg_d_d = (SEG_D_A == ZERO_A)   ? ZERO_D : mem_q[SEG_D_A];
`ifdef REGFILE_BYPASS_EN
    // An accepted write never targets address 0, so forwarding keeps R0 at zero.
    r1_d    = (wr_acc_s && (i_r1_addr == i_w_addr)) ? i_w_data : r1_d;
    r2_d    = (wr_acc_s && (i_r2_addr == i_w_addr)) ? i_w_data : r2_d;
    seg_c_d = (wr_acc_s && (SEG_C_A == i_w_addr))   ? i_w_data : seg_c_d;
    seg_d_d = (wr_acc_s && (SEG_D_A == i_w_addr))   ? i_w_data : seg_d_d;
`endif
  end

  // Output registers, held while the clock enable is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r1_q    <= ZERO_D;
      r2_q    <= ZERO_D;
      seg_c_q <= ZERO_D;
      seg_d_q <= ZERO_D;
    end else if (i_ce) begin
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      seg_c_q <= seg_c_d;
      seg_d_q <= seg_d_d;
    end
  end

  assign o_r1_data = r1_q;
  assign o_r2_data = r2_q;
  assign o_seg_c   = seg_c_q;
  assign o_seg_d   = seg_d_q;
  assign o_busy    = busy_s;

endmodule

// File: tb/tb_reg_file_gen.sv
// Self-checking bench for reg_file_gen: directed scenarios plus randomized traffic against a reference model.
module tb_reg_file_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0, we = 1'b0, clr = 1'b0;
  logic [3:0]  w_addr = 4'd0, r1_addr = 4'd0, r2_addr = 4'd0;
  logic [15:0] w_data = 16'h0;
  logic [15:0] r1_data, r2_data, seg_c, seg_d;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_mem [16];
  int          m_left;
  logic [15:0] e_r1, e_r2, e_c, e_d;
  logic        e_busy;

  reg_file_gen dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_ce      (ce),
    .i_we      (we),
    .i_w_addr  (w_addr),
    .i_w_data  (w_data),
    .i_r1_addr (r1_addr),
    .i_r2_addr (r2_addr),
    .i_clr     (clr),
    .o_r1_data (r1_data),
    .o_r2_data (r2_data),
    .o_seg_c   (seg_c),
    .o_seg_d   (seg_d),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
    m_left = 0;
    e_r1 = 16'h0; e_r2 = 16'h0; e_c = 16'h0; e_d = 16'h0; e_busy = 1'b0;
  endfunction

  function automatic logic m_accept();
    return ce && we && (w_addr != 4'd0) && (m_left == 0) && !clr;
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] a);
    if (a == 4'd0) return 16'h0;
`ifdef REGFILE_BYPASS_EN
    if (m_accept() && (a == w_addr)) return w_data;
`endif
    return m_mem[a];
  endfunction

  // One clock edge: update the reference model from the inputs present at the edge.
  task automatic step();
    @(posedge clk);
    if (ce) begin
      e_r1 = m_read(r1_addr);
      e_r2 = m_read(r2_addr);
      e_c  = m_read(4'd14);
      e_d  = m_read(4'd15);
      if (m_left > 0) begin
        m_mem[16 - m_left] = 16'h0;
        m_left--;
      end else if (clr) begin
        m_left = 15;
      end else if (m_accept()) begin
        m_mem[w_addr] = w_data;
      end
      e_busy = (m_left != 0);
    end
    #1;
  endtask

  task automatic test_reset();
    m_reset();
    #2;
    checks++; if (r1_data !== 16'h0) begin failures++; $display("FAIL reset_r1 got=%h exp=0000", r1_data); end
    checks++; if (r2_data !== 16'h0) begin failures++; $display("FAIL reset_r2 got=%h exp=0000", r2_data); end
    checks++; if (seg_c !== 16'h0 || seg_d !== 16'h0) begin failures++; $display("FAIL reset_seg got=%h/%h exp=0000/0000", seg_c, seg_d); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    #1 rst_n = 1'b1;
    ce = 1'b1; r1_addr = 4'd3; r2_addr = 4'd0;
    step();
    checks++; if (r1_data !== 16'h0 || r2_data !== 16'h0) begin failures++; $display("FAIL read_after_reset got=%h/%h exp=0000/0000", r1_data, r2_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_reset got=%b exp=0", busy); end
  endtask

  task automatic test_write_read();
    we = 1'b1; w_addr = 4'd5; w_data = 16'hBEEF; step();
    we = 1'b0; r1_addr = 4'd5; step();
    checks++; if (r1_data !== 16'hBEEF) begin failures++; $display("FAIL read_r5 got=%h exp=BEEF", r1_data); end
    we = 1'b1; w_addr = 4'd0; w_data = 16'h1234; step();
    we = 1'b0; r1_addr = 4'd0; r2_addr = 4'd0; step();
    checks++; if (r1_data !== 16'h0 || r2_data !== 16'h0) begin failures++; $display("FAIL read_r0 got=%h/%h exp=0000/0000", r1_data, r2_data); end
  endtask

  task automatic test_rbw();
    logic [15:0] exp_v;
    we = 1'b1; w_addr = 4'd7; w_data = 16'h1111; step();
    w_data = 16'hA5A5; r1_addr = 4'd7; r2_addr = 4'd7; step();
`ifdef REGFILE_BYPASS_EN
    exp_v = 16'hA5A5;
`else
    exp_v = 16'h1111;
`endif
    checks++; if (r1_data !== exp_v || r2_data !== exp_v) begin failures++; $display("FAIL same_cycle_rw got=%h/%h exp=%h", r1_data, r2_data, exp_v); end
    we = 1'b0; step();
    checks++; if (r1_data !== 16'hA5A5) begin failures++; $display("FAIL read_after_rw got=%h exp=A5A5", r1_data); end
  endtask

  task automatic test_seg();
    we = 1'b1; w_addr = 4'd14; w_data = 16'h8000; step();
    we = 1'b0; step();
    checks++; if (seg_c !== 16'h8000) begin failures++; $display("FAIL seg_c got=%h exp=8000", seg_c); end
    we = 1'b1; w_addr = 4'd15; w_data = 16'h9000; step();
    we = 1'b0; step();
    checks++; if (seg_d !== 16'h9000 || seg_c !== 16'h8000) begin failures++; $display("FAIL seg_d got=%h/%h exp=8000/9000", seg_c, seg_d); end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 1; i < 16; i++) begin
      we = 1'b1; w_addr = 4'(i); w_data = 16'(i) * 16'h1111; step();
    end
    clr = 1'b1; w_addr = 4'd3; w_data = 16'h7777; step();
    clr = 1'b0; w_addr = 4'd9; w_data = 16'hFFFF;
    n = (busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < 40 && busy === 1'b1; k++) begin
      step();
      if (busy === 1'b1) n++;
    end
    checks++; if (n != 15) begin failures++; $display("FAIL busy_len got=%0d exp=15", n); end
    we = 1'b0;
    for (int a = 0; a < 16; a++) begin
      r1_addr = 4'(a); r2_addr = 4'(15 - a); step();
      checks++; if (r1_data !== 16'h0 || r2_data !== 16'h0 || r1_data !== e_r1) begin failures++; $display("FAIL cleared_r%0d got=%h/%h exp=0000/0000", a, r1_data, r2_data); end
    end
  endtask

  task automatic test_freeze_reset();
    for (int i = 12; i < 16; i++) begin
      we = 1'b1; w_addr = 4'(i); w_data = 16'h0C0C + 16'(i); step();
    end
    we = 1'b0; r1_addr = 4'd12; r2_addr = 4'd13; step();
    clr = 1'b1; step();
    clr = 1'b0; step(); step();
    ce = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL freeze_busy cyc=%0d got=%b exp=1", k, busy); end
      checks++; if (r1_data !== e_r1 || r1_data !== 16'h0C18) begin failures++; $display("FAIL freeze_r1 got=%h exp=%h", r1_data, e_r1); end
    end
    ce = 1'b1; step();
    checks++; if (busy !== e_busy || r1_data !== 16'h0C18) begin failures++; $display("FAIL resume got=%b/%h exp=%b/0C18", busy, r1_data, e_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
    checks++; if (r1_data !== 16'h0 || r2_data !== 16'h0 || seg_c !== 16'h0 || seg_d !== 16'h0) begin
      failures++; $display("FAIL async_rst_out got=%h/%h/%h/%h exp=0", r1_data, r2_data, seg_c, seg_d); end
    m_reset();
    #2 rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || r1_data !== 16'h0) begin failures++; $display("FAIL after_rst got=%b/%h exp=0/0000", busy, r1_data); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      ce      = ($urandom_range(0, 7) != 0);
      we      = 1'($urandom_range(0, 1));
      w_addr  = 4'($urandom_range(0, 15));
      w_data  = 16'($urandom);
      r1_addr = ($urandom_range(0, 3) == 0) ? w_addr : 4'($urandom_range(0, 15));
      r2_addr = ($urandom_range(0, 3) == 0) ? w_addr : 4'($urandom_range(0, 15));
      clr     = ($urandom_range(0, 49) == 0);
      step();
      checks++; if (r1_data !== e_r1) begin failures++; $display("FAIL rnd_r1 cyc=%0d got=%h exp=%h", k, r1_data, e_r1); end
      checks++; if (r2_data !== e_r2) begin failures++; $display("FAIL rnd_r2 cyc=%0d got=%h exp=%h", k, r2_data, e_r2); end
      checks++; if (seg_c !== e_c) begin failures++; $display("FAIL rnd_seg_c cyc=%0d got=%h exp=%h", k, seg_c, e_c); end
      checks++; if (seg_d !== e_d) begin failures++; $display("FAIL rnd_seg_d cyc=%0d got=%h exp=%h", k, seg_d, e_d); end
      checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", k, busy, e_busy); end
    end
    ce = 1'b1; we = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rbw();
    test_seg();
    test_clear();
    test_freeze_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
